// File: rtl/component_pkg.sv
// Shared defaults and helpers for the elastic delay line.
package component_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_CYCLES = 4;

    // Width of an occupancy counter able to hold 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/component_elastic_delay_if.sv
// Valid/ready payload stream used on both sides of the elastic delay line.
interface component_elastic_delay_if
    import component_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/component_pipe_stage.sv
// One elastic register stage: holds a single {valid,data} item.
module component_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);
    logic             vld_p0;
    logic [WIDTH-1:0] dat_p0;

    // The slot can take a new item when it is empty or its item leaves this cycle.
    assign up_ready = !vld_p0 || dn_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            dat_p0 <= '0;
        end else if (up_ready) begin
            vld_p0 <= up_valid;
            if (up_valid) begin
                dat_p0 <= up_data;
            end
        end
    end

    assign dn_valid = vld_p0;
    assign dn_data  = dat_p0;
endmodule

// File: rtl/component_elastic_delay.sv
// Flow-controlled CYCLES-deep delay line with bubble compression and occupancy count.
module component_elastic_delay
    import component_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int CYCLES = DEFAULT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    component_elastic_delay_if.slave      up,
    component_elastic_delay_if.master     dn,
    output logic [cnt_w(CYCLES)-1:0]      count,
    output logic                          empty
);
    localparam int CW = cnt_w(CYCLES);

    logic             vld [0:CYCLES];
    logic             rdy [0:CYCLES];
    logic [WIDTH-1:0] dat [0:CYCLES];
    logic [CW-1:0]    cnt_r;
    logic             in_fire;
    logic             out_fire;

    assign vld[0]      = up.valid;
    assign dat[0]      = up.data;
    assign up.ready    = rdy[0];
    assign rdy[CYCLES] = dn.ready;

    for (genvar k = 0; k < CYCLES; k++) begin : g_stage
        component_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_data  (dat[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_data  (dat[k+1])
        );
    end

    assign dn.valid = vld[CYCLES];
    assign dn.data  = dat[CYCLES];

    assign in_fire  = up.valid && rdy[0];
    assign out_fire = vld[CYCLES] && dn.ready;

    // Simultaneous accept and retire leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign count = cnt_r;
    assign empty = (cnt_r == '0);
endmodule

// File: tb/tb_component_elastic_delay.sv
// Directed bench for the elastic delay line (CYCLES=4 and CYCLES=1 instances).
module tb_component_elastic_delay;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    component_elastic_delay_if #(.WIDTH(8)) a_up ();
    component_elastic_delay_if #(.WIDTH(8)) a_dn ();
    component_elastic_delay_if #(.WIDTH(8)) b_up ();
    component_elastic_delay_if #(.WIDTH(8)) b_dn ();

    logic [2:0] a_count;
    logic       a_empty;
    logic [0:0] b_count;
    logic       b_empty;

    component_elastic_delay #(.WIDTH(8), .CYCLES(4)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .up    (a_up),
        .dn    (a_dn),
        .count (a_count),
        .empty (a_empty)
    );

    component_elastic_delay #(.WIDTH(8), .CYCLES(1)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .up    (b_up),
        .dn    (b_dn),
        .count (b_count),
        .empty (b_empty)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record what retires on the coming edge, then take the edge.
    task automatic fire_tick();
        if (a_dn.valid && a_dn.ready) qa.push_back(a_dn.data);
        if (b_dn.valid && b_dn.ready) qb.push_back(b_dn.data);
        tick();
    endtask

    initial begin
        int first_t, last_t, cnt_bad, seen;

        a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
        b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;

        // ---- 1: reset state, then reset mid-stream
        tick(); tick();
        chk("rst_out_valid", 32'(a_dn.valid), 32'd0);
        chk("rst_out_data",  32'(a_dn.data),  32'd0);
        chk("rst_count",     32'(a_count),    32'd0);
        chk("rst_empty",     32'(a_empty),    32'd1);
        chk("rst_in_ready",  32'(a_up.ready), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_up.valid = 1'b1; a_up.data = 8'h31 + 8'(i);
            tick();
        end
        a_up.valid = 1'b0;
        chk("t1_count_pre", 32'(a_count), 32'd3);
        rst = 1'b0;
        #1;
        chk("t1_async_valid", 32'(a_dn.valid), 32'd0);
        chk("t1_async_count", 32'(a_count),    32'd0);
        tick(); tick();
        rst = 1'b1;
        a_dn.ready = 1'b1;
        chk("t1_out_data",  32'(a_dn.data),  32'd0);
        chk("t1_empty",     32'(a_empty),    32'd1);
        chk("t1_in_ready",  32'(a_up.ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_dn.valid) seen++;
        end
        chk("t1_nothing_out", 32'(seen), 32'd0);

        // ---- 2: back-to-back stream 0x01..0x10 with out_ready=1
        first_t = -1; last_t = -1; cnt_bad = 0; qa.delete();
        for (int t = 1; t <= 22; t++) begin
            if (t <= 16) begin
                a_up.valid = 1'b1; a_up.data = 8'(t);
            end else begin
                a_up.valid = 1'b0;
            end
            tick();
            if (a_dn.valid) begin
                qa.push_back(a_dn.data);
                if (first_t < 0) first_t = t;
                last_t = t;
            end
            if (t >= 4 && t <= 16 && a_count != 3'd4) cnt_bad++;
        end
        chk("t2_first_edge", 32'(first_t), 32'd4);
        chk("t2_last_edge",  32'(last_t),  32'd19);
        chk("t2_count_4",    32'(cnt_bad), 32'd0);
        chk("t2_n_items",    32'(qa.size()), 32'd16);
        for (int i = 0; i < qa.size(); i++) chk("t2_item", 32'(qa[i]), 32'(i + 1));
        chk("t2_drained", 32'(a_empty), 32'd1);

        // ---- 3: backpressure 0xA0..0xA4
        a_dn.ready = 1'b0; qa.delete(); seen = 0;
        for (int i = 0; i < 4; i++) begin
            a_up.valid = 1'b1; a_up.data = 8'hA0 + 8'(i);
            #1;
            if (a_up.ready) seen++;
            tick();
        end
        chk("t3_first4_ready", 32'(seen), 32'd4);
        a_up.data = 8'hA4;
        #1;
        chk("t3_ready_full", 32'(a_up.ready), 32'd0);
        chk("t3_count_full", 32'(a_count),    32'd4);
        a_dn.ready = 1'b1;
        #1;
        chk("t3_ready_release", 32'(a_up.ready), 32'd1);
        fire_tick();
        a_up.valid = 1'b0;
        chk("t3_count_swap", 32'(a_count), 32'd4);
        for (int i = 0; i < 6; i++) fire_tick();
        chk("t3_n_items", 32'(qa.size()), 32'd5);
        for (int i = 0; i < qa.size(); i++) chk("t3_item", 32'(qa[i]), 32'hA0 + 32'(i));

        // ---- 4: bubbles compress behind a stalled item
        a_dn.ready = 1'b0; qa.delete();
        a_up.valid = 1'b1; a_up.data = 8'h11; tick();
        a_up.valid = 1'b0; tick(); tick();
        a_up.valid = 1'b1; a_up.data = 8'h22; tick();
        a_up.valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_count",      32'(a_count),    32'd2);
        chk("t4_hold_valid", 32'(a_dn.valid), 32'd1);
        chk("t4_hold_data",  32'(a_dn.data),  32'h11);
        a_dn.ready = 1'b1;
        fire_tick(); fire_tick();
        chk("t4_n_items", 32'(qa.size()), 32'd2);
        if (qa.size() == 2) begin
            chk("t4_item0", 32'(qa[0]), 32'h11);
            chk("t4_item1", 32'(qa[1]), 32'h22);
        end
        chk("t4_empty", 32'(a_empty), 32'd1);

        // ---- 5: full with simultaneous accept and retire
        a_dn.ready = 1'b0; qa.delete();
        for (int i = 0; i < 4; i++) begin
            a_up.valid = 1'b1; a_up.data = 8'h51 + 8'(i); tick();
        end
        chk("t5_count_full", 32'(a_count), 32'd4);
        a_up.data = 8'h55; a_dn.ready = 1'b1;
        #1;
        chk("t5_in_ready", 32'(a_up.ready), 32'd1);
        fire_tick();
        a_up.valid = 1'b0;
        chk("t5_count_same", 32'(a_count), 32'd4);
        for (int i = 0; i < 6; i++) fire_tick();
        chk("t5_n_items", 32'(qa.size()), 32'd5);
        for (int i = 0; i < qa.size(); i++) chk("t5_item", 32'(qa[i]), 32'h51 + 32'(i));

        // ---- 6: CYCLES=1 instance
        b_dn.ready = 1'b0; qb.delete();
        b_up.valid = 1'b1; b_up.data = 8'h7E; tick();
        b_up.data = 8'h7F;
        #1;
        chk("t6_out_valid", 32'(b_dn.valid), 32'd1);
        chk("t6_out_data",  32'(b_dn.data),  32'h7E);
        chk("t6_in_ready",  32'(b_up.ready), 32'd0);
        chk("t6_count",     32'(b_count),    32'd1);
        b_dn.ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            b_up.data = 8'h7F + 8'(i);
            #1;
            if (b_up.ready) seen++;
            fire_tick();
        end
        b_up.valid = 1'b0;
        fire_tick(); fire_tick();
        chk("t6_ready_cycles", 32'(seen), 32'd3);
        chk("t6_n_items", 32'(qb.size()), 32'd4);
        for (int i = 0; i < qb.size(); i++) chk("t6_item", 32'(qb[i]), 32'h7E + 32'(i));
        chk("t6_empty", 32'(b_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
